sara_dar_accuracy_ctrl: RTL

- Variable-latency accuracy controller around a SIZE-bit SARA-DAR style segmented adder.
- Accepts operand pairs over valid/ready and produces a one-cycle approximate sum.
- Detects every group boundary where the approximate carry speculation was used.
- Depending on mode, either returns the approximate result or recomputes the exact sum serially, one GROUP-bit slice per cycle.
- Sits between the operand source and downstream accumulate logic; keeps a saturating correction counter.

---
 rtl/sara_dar_pkg.sv | 25 ++
 rtl/sara_dar_boundary_detect.sv | 48 ++++
 rtl/sara_dar_accuracy_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sara_dar_pkg.sv
// Shared types for the SARA-DAR accuracy controller.
// Mode encodings, FSM states and the slice index width helper.
package sara_dar_pkg;

  localparam logic [1:0] MODE_APPROX = 2'b00;
  localparam logic [1:0] MODE_DETECT = 2'b01;
  localparam logic [1:0] MODE_EXACT  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_CORR,
    S_HOLD
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sara_dar_boundary_detect.sv
// Boundary speculation detector and approximate group carry chain.
// A group speculates its carry-in from g below the boundary when D_k fires.
module sara_dar_boundary_detect #(
  parameter int SIZE   = 16,
  parameter int GROUP  = 8,
  parameter int WINDOW = 2,
  parameter int NG     = SIZE / GROUP
) (
  input  logic [SIZE-1:0] p_i,
  input  logic [SIZE-1:0] g_i,
  input  logic            cin_i,
  output logic [NG-1:0]   det_o,
  output logic [NG-1:0]   gcin_o,
  output logic            cout_o
);

  function automatic logic ripple(
    input logic [GROUP-1:0] p,
    input logic [GROUP-1:0] g,
    input logic             c
  );
    logic r;
    r = c;
    for (int j = 0; j < GROUP; j++) begin
      r = g[j] | (p[j] & r);
    end
    return r;
  endfunction

  always_comb begin
    logic c;
    logic d;
    det_o     = '0;
    gcin_o    = '0;
    gcin_o[0] = cin_i;
    c = ripple(p_i[GROUP-1:0], g_i[GROUP-1:0], cin_i);
    for (int k = 1; k < NG; k++) begin
      d        = &p_i[k*GROUP +: WINDOW];
      det_o[k] = d;
      if (d) c = g_i[k*GROUP-1];
      gcin_o[k] = c;
      c = ripple(p_i[k*GROUP +: GROUP],
                 g_i[k*GROUP +: GROUP], c);
    end
    cout_o = c;
  end

endmodule

// File: rtl/sara_dar_accuracy_ctrl.sv
// Variable-latency accuracy controller around a SARA-DAR adder.
// Approximate in one cycle, or exact via a serial GROUP-bit slice adder.
module sara_dar_accuracy_ctrl
  import sara_dar_pkg::*;
#(
  parameter int SIZE   = 16,
  parameter int GROUP  = 8,
  parameter int WINDOW = 2,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_a,
  input  logic [SIZE-1:0] in_b,
  input  logic            in_cin,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_sum,
  output logic            out_cout,
  output logic            out_approx,
  output logic            out_corrected,
  output logic [CNTW-1:0] corr_count,
  input  logic            stat_clr
);

  localparam int NG = SIZE / GROUP;
  localparam int IW = clog2(NG);

  state_e state_q, state_d;
  logic [SIZE-1:0] a_q, a_d, b_q, b_d;
  logic            cin_q, cin_d;
  logic [1:0]      mode_q, mode_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [SIZE-1:0] acc_q, acc_d;
  logic [SIZE-1:0] sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            apx_q, apx_d;
  logic            cor_q, cor_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [SIZE-1:0] p, g, asum;
  logic [NG-1:0]   det, gcin;
  logic            acout, dany, inc;
  logic [GROUP-1:0] as, bs;
  logic [GROUP:0]   st;

  assign p    = a_q ^ b_q;
  assign g    = a_q & b_q;
  assign dany = |det;

  sara_dar_boundary_detect #(
    .SIZE  (SIZE),
    .GROUP (GROUP),
    .WINDOW(WINDOW),
    .NG    (NG)
  ) u_det (
    .p_i   (p),
    .g_i   (g),
    .cin_i (cin_q),
    .det_o (det),
    .gcin_o(gcin),
    .cout_o(acout)
  );

  always_comb begin
    for (int k = 0; k < NG; k++) begin
      asum[k*GROUP +: GROUP] = a_q[k*GROUP +: GROUP]
                             + b_q[k*GROUP +: GROUP]
                             + GROUP'(gcin[k]);
    end
  end

  always_comb begin
    as = '0;
    bs = '0;
    for (int i = 0; i < NG; i++) begin
      if (idx_q == IW'(i)) begin
        as = a_q[i*GROUP +: GROUP];
        bs = b_q[i*GROUP +: GROUP];
      end
    end
    st = {1'b0, as} + {1'b0, bs} + {{GROUP{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    apx_d   = apx_q;
    cor_d   = cor_q;
    inc     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          mode_d  = in_mode;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (mode_q == MODE_APPROX ||
            (mode_q == MODE_DETECT && !dany)) begin
          sum_d   = asum;
          cout_d  = acout;
          apx_d   = (mode_q == MODE_APPROX) & dany;
          cor_d   = 1'b0;
          state_d = S_HOLD;
        end else begin
          idx_d   = '0;
          carry_d = cin_q;
          acc_d   = '0;
          state_d = S_CORR;
        end
      end
      S_CORR: begin
        for (int i = 0; i < NG; i++) begin
          if (idx_q == IW'(i)) acc_d[i*GROUP +: GROUP] = st[GROUP-1:0];
        end
        carry_d = st[GROUP];
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NG-1)) begin
          sum_d   = acc_d;
          cout_d  = st[GROUP];
          apx_d   = 1'b0;
          cor_d   = (mode_q == MODE_DETECT);
          inc     = (mode_q == MODE_DETECT);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear wins over a same-cycle correction.
  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr) cnt_d = '0;
    else if (inc && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      mode_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      apx_q   <= 1'b0;
      cor_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      apx_q   <= apx_d;
      cor_q   <= cor_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_HOLD);
  assign out_sum       = sum_q;
  assign out_cout      = cout_q;
  assign out_approx    = apx_q;
  assign out_corrected = cor_q;
  assign corr_count    = cnt_q;

endmodule
